// File: rtl/alu_pkg.sv
// Shared constants and types for the adder result-capture stage.
// Flag layout in every 4-bit flag vector is {C,Z,N,V}.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Encodings equal the entry count so the state doubles as count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  function automatic logic [3:0] pack_flags(
    input logic c,
    input logic z,
    input logic n,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_gen_8bit.sv
// Derives C/Z/N/V and the captured result from the adder outputs.
// Define ACC_SAT_EN to clamp signed overflow to 0x7F/0x80.
import alu_pkg::*;

module flag_gen_8bit #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  input  logic             sel,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic same_sign;
  logic ovf;

  // Subtract feeds ~B to the adder, so operand signs must differ.
  assign same_sign = (a_msb == b_msb);
  assign ovf = (sel ? !same_sign : same_sign)
             & (sum[WIDTH-1] != a_msb);

`ifdef ACC_SAT_EN
  always_comb begin
    result = sum;
    if (ovf) begin
      if (a_msb)
        result = {1'b1, {(WIDTH-1){1'b0}}};
      else
        result = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign result = sum;
`endif

  assign flags = pack_flags(
    c_out,
    (result == '0),
    result[WIDTH-1],
    ovf
  );

endmodule

// File: rtl/acc_flags_8bit.sv
// Accumulator plus 2-entry result/flag buffer behind the 8-bit adder.
// Optional saturation is enabled with the ACC_SAT_EN macro.
import alu_pkg::*;

module acc_flags_8bit #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int DEPTH = alu_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  input  logic             sel,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_flags
);

  buf_state_t state;
  buf_state_t state_n;

  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  logic [WIDTH-1:0] data_mem [2];
  logic [3:0]       flag_mem [2];
  logic             head;
  logic             tail;
  logic             head_n;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] nxt_data;
  logic [3:0]       nxt_flags;

  flag_gen_8bit #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .sum    (sum),
    .c_out  (c_out),
    .sel    (sel),
    .a_msb  (a_msb),
    .b_msb  (b_msb),
    .result (result),
    .flags  (flags)
  );

  assign in_ready  = (state != buf_state_t'(DEPTH));
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: begin
        if (push)
          state_n = ONE;
      end
      ONE: begin
        if (push && !pop)
          state_n = FULL;
        else if (pop && !push)
          state_n = EMPTY;
      end
      FULL: begin
        if (pop)
          state_n = ONE;
      end
      default: state_n = EMPTY;
    endcase
  end

  // Output registers track the entry that will be head after this edge.
  always_comb begin
    head_n    = pop ? ~head : head;
    nxt_data  = data_mem[head_n];
    nxt_flags = flag_mem[head_n];
    if (push && (tail == head_n)) begin
      nxt_data  = result;
      nxt_flags = flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= 1'b0;
      tail        <= 1'b0;
      data_mem[0] <= '0;
      data_mem[1] <= '0;
      flag_mem[0] <= '0;
      flag_mem[1] <= '0;
    end else begin
      head <= head_n;
      if (push) begin
        data_mem[tail] <= result;
        flag_mem[tail] <= flags;
        tail           <= ~tail;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_flags <= '0;
    end else if (state_n != EMPTY) begin
      out_data  <= nxt_data;
      out_flags <= nxt_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (push)
      acc <= result;
  end

endmodule
